// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-Lite master.
// Turns a valid/ready command stream into pipelined NONSEQ transfers and
// returns one response pulse per command, in issue order. A two-cycle ERROR
// response cancels the transfer waiting in its address phase; that transfer
// is re-issued exactly once after the errored data phase completes.
module ahb_lite_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Error-handling state. err1 and replay are decoded from it.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,  // normal pipelined operation
    ST_ERR     = 2'd1,  // between the two ERROR cycles, nothing cancelled
    ST_ERR_RPL = 2'd2,  // between the two ERROR cycles, address phase cancelled
    ST_RPL     = 2'd3   // re-issuing the cancelled transfer
  } state_e;

  state_e state_q, state_d;

  logic                  err1_s;
  logic                  replay_s;
  logic                  accept_s;
  logic                  first_err_s;

  // Address phase
  logic                  nonseq_q, nonseq_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  // Data phase
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  // Response
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  // First ERROR cycle: slave flags ERROR while still stalling the data phase.
  assign first_err_s = dp_valid_q & HRESP & ~HREADY;
  assign accept_s    = cmd_valid & cmd_ready;

  // Error-handling state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Error-handling next state: the second ERROR cycle is the one with HREADY high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (first_err_s) begin
          state_d = nonseq_q ? ST_ERR_RPL : ST_ERR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_ERR_RPL: begin
        if (HREADY) begin
          state_d = ST_RPL;
        end else begin
          state_d = ST_ERR_RPL;
        end
      end
      ST_RPL: begin
        if (HREADY) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RPL;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Error-handling outputs: flag decode and command backpressure.
  always_comb begin
    err1_s   = 1'b0;
    replay_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        err1_s   = 1'b0;
        replay_s = 1'b0;
      end
      ST_ERR: begin
        err1_s   = 1'b1;
        replay_s = 1'b0;
      end
      ST_ERR_RPL: begin
        err1_s   = 1'b1;
        replay_s = 1'b1;
      end
      ST_RPL: begin
        err1_s   = 1'b0;
        replay_s = 1'b1;
      end
      default: begin
        err1_s   = 1'b0;
        replay_s = 1'b0;
      end
    endcase
    cmd_ready = ~rst & HREADY & ~err1_s & ~replay_s;
  end

  // Datapath next values: address phase, data phase and response.
  always_comb begin
    nonseq_d    = nonseq_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    wdata_d     = wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    // Address phase. Cancelled fields are kept so a replay needs no extra storage.
    if (err1_s) begin
      if (HREADY) begin
        nonseq_d = replay_s;
      end else begin
        nonseq_d = 1'b0;
      end
    end else if (first_err_s) begin
      nonseq_d = 1'b0;
    end else if (HREADY) begin
      nonseq_d = accept_s;
      if (accept_s) begin
        haddr_d  = cmd_addr;
        hwrite_d = cmd_write;
        hsize_d  = cmd_size;
        wdata_d  = cmd_wdata;
      end else begin
        haddr_d  = haddr_q;
      end
    end else begin
      nonseq_d = nonseq_q;
    end

    // Data phase advances only when the bus is ready.
    if (HREADY) begin
      dp_valid_d = nonseq_q;
      if (nonseq_q) begin
        dp_write_d = hwrite_q;
        hwdata_d   = wdata_q;
      end else begin
        dp_write_d = dp_write_q;
      end
    end else begin
      dp_valid_d = dp_valid_q;
    end

    // Response pulse one cycle after data-phase completion.
    if (dp_valid_q && HREADY) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = dp_write_q ? {DATA_WIDTH{1'b0}} : HRDATA;
      rsp_error_d = HRESP;
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nonseq_q    <= 1'b0;
      haddr_q     <= {ADDR_WIDTH{1'b0}};
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      wdata_q     <= {DATA_WIDTH{1'b0}};
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_error_q <= 1'b0;
    end else begin
      nonseq_q    <= nonseq_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      wdata_q     <= wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HTRANS    = nonseq_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign busy      = nonseq_q | dp_valid_q | err1_s | replay_s;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed scenarios plus a randomized run against a
// transaction-level model (in-order response queue and a word memory).
module tb_ahb_lite_master;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_lite_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic drive_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_cmd(1'b1, 1'b1, 32'hFFFF_FFFC, 3'd2, 32'h1234_5678);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (HTRANS !== 2'b00 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_bus: HTRANS=%b cmd_ready=%b, want 00 and 0", HTRANS, cmd_ready);
    end
    checks++;
    if (HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 || HWDATA !== 32'h0) begin
      errors++; $display("FAIL reset_addr: HADDR=%h HWRITE=%b HSIZE=%0d HWDATA=%h, want all 0", HADDR, HWRITE, HSIZE, HWDATA);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: rsp_valid=%b rsp_rdata=%h rsp_error=%b busy=%b, want all 0", rsp_valid, rsp_rdata, rsp_error, busy);
    end
    checks++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      errors++; $display("FAIL reset_const: HBURST=%b HPROT=%b, want 000 0011", HBURST, HPROT);
    end
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h5555_AAAA;
    drive_cmd(1'b1, 1'b1, 32'h0000_0004, 3'd2, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL sw_ready: cmd_ready=%b, want 1", cmd_ready);
    end
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h4 || HWRITE !== 1'b1 || HSIZE !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL sw_addr_phase: HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d busy=%b, want 10/4/1/2/1", HTRANS, HADDR, HWRITE, HSIZE, busy);
    end
    @(negedge clk);
    checks++;
    if (HTRANS !== 2'b00 || HWDATA !== 32'hDEAD_BEEF || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sw_data_phase: HTRANS=%b HWDATA=%h rsp_valid=%b busy=%b, want 00/deadbeef/0/1", HTRANS, HWDATA, rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL sw_rsp: rsp_valid=%b rsp_error=%b rsp_rdata=%h busy=%b, want 1/0/0/0", rsp_valid, rsp_error, rsp_rdata, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL sw_rsp_pulse: rsp_valid=%b rsp_rdata=%h, want 0 and held 0", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
    drive_cmd(1'b1, 1'b1, 32'h0000_0004, 3'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0004, 3'd2, 32'h0);
    checks++;
    if (HTRANS !== 2'b10 || HWRITE !== 1'b1) begin
      errors++; $display("FAIL b2b_first: HTRANS=%b HWRITE=%b, want 10/1", HTRANS, HWRITE);
    end
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    checks++;
    if (HTRANS !== 2'b10 || HWRITE !== 1'b0 || HADDR !== 32'h4 || HWDATA !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_second: HTRANS=%b HWRITE=%b HADDR=%h HWDATA=%h, want 10/0/4/deadbeef", HTRANS, HWRITE, HADDR, HWDATA);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp_write: rsp_valid=%b rsp_rdata=%h rsp_error=%b, want 1/0/0", rsp_valid, rsp_rdata, rsp_error);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_error !== 1'b0) begin
      errors++; $display("FAIL b2b_rsp_read: rsp_valid=%b rsp_rdata=%h rsp_error=%b, want 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_error);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_done: rsp_valid=%b busy=%b, want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_wait_states();
    int pulses;
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_cmd(1'b1, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 32'h0000_0020, 3'd1, 32'h3333_4444);
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 32'h0000_0030, 3'd2, 32'h7777_7777);
    HREADY = 1'b0;
    #1;
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h20 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ws_start: HTRANS=%b HADDR=%h cmd_ready=%b, want 10/20/0", HTRANS, HADDR, cmd_ready);
    end
    pulses = 0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
      #1;
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h20 || HWRITE !== 1'b1 || HSIZE !== 3'd1 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL ws_hold: wait %0d HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d cmd_ready=%b, want 10/20/1/1/0", w, HTRANS, HADDR, HWRITE, HSIZE, cmd_ready);
      end
    end
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0 || HWDATA !== 32'h3333_4444) begin
      errors++; $display("FAIL ws_rsp_read: rsp_valid=%b rsp_rdata=%h rsp_error=%b HWDATA=%h, want 1/12345678/0/33334444", rsp_valid, rsp_rdata, rsp_error, HWDATA);
    end
    if (rsp_valid === 1'b1) pulses++;
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL ws_pulse_count: %0d read pulses, want 1", pulses);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL ws_rsp_write: rsp_valid=%b rsp_rdata=%h, want 1/0", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_error_replay();
    int pulses;
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_cmd(1'b1, 1'b1, 32'h0000_0040, 3'd2, 32'h1111_2222);
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0050, 3'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    pulses = (rsp_valid === 1'b1) ? 1 : 0;
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge clk);
    if (rsp_valid === 1'b1) pulses++;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h50 || busy !== 1'b1) begin
      errors++; $display("FAIL err_idle: HTRANS=%b HADDR=%h busy=%b, want 00/50/1", HTRANS, HADDR, busy);
    end
    HREADY = 1'b1; HRESP = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL err_ready: cmd_ready=%b in second error cycle, want 0", cmd_ready);
    end
    @(negedge clk);
    if (rsp_valid === 1'b1) pulses++;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
      errors++; $display("FAIL err_rsp_a: rsp_valid=%b rsp_error=%b, want 1/1", rsp_valid, rsp_error);
    end
    checks++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h50 || HWRITE !== 1'b0) begin
      errors++; $display("FAIL err_replay: HTRANS=%b HADDR=%h HWRITE=%b, want 10/50/0", HTRANS, HADDR, HWRITE);
    end
    HRESP = 1'b0;
    drive_cmd(1'b1, 1'b1, 32'h0000_0099, 3'd2, 32'h0);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL err_replay_ready: cmd_ready=%b during replay, want 0", cmd_ready);
    end
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    if (rsp_valid === 1'b1) pulses++;
    HRDATA = 32'hCAFE_F00D;
    checks++;
    if (HTRANS !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL err_replay_once: HTRANS=%b busy=%b, want 00/1", HTRANS, busy);
    end
    @(negedge clk);
    if (rsp_valid === 1'b1) pulses++;
    HRDATA = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL err_rsp_b: rsp_valid=%b rsp_error=%b rsp_rdata=%h, want 1/0/cafef00d", rsp_valid, rsp_error, rsp_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL err_pulse_count: %0d pulses busy=%b, want 2/0", pulses, busy);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    drive_cmd(1'b1, 1'b0, 32'h0000_0060, 3'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    HREADY = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 || HWDATA !== 32'h0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_async: HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d HWDATA=%h busy=%b rsp_valid=%b, want all 0", HTRANS, HADDR, HWRITE, HSIZE, HWDATA, busy, rsp_valid);
    end
    @(negedge clk);
    HREADY = 1'b1; HRDATA = 32'h9999_9999;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin
        errors++; $display("FAIL abort_no_rsp: rsp_valid=%b HTRANS=%b, want 0/00", rsp_valid, HTRANS);
      end
    end
    drive_cmd(1'b1, 1'b0, 32'h0000_0070, 3'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    HRDATA = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_error !== 1'b0) begin
      errors++; $display("FAIL abort_recover: rsp_valid=%b rsp_rdata=%h rsp_error=%b, want 1/0badf00d/0", rsp_valid, rsp_rdata, rsp_error);
    end
    HRDATA = 32'h0;
  endtask

  task automatic test_idle();
    drive_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (HTRANS !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL idle: cycle %0d HTRANS=%b busy=%b rsp_valid=%b, want 00/0/0", c, HTRANS, busy, rsp_valid);
      end
    end
  endtask

  // Random traffic against a word memory; addresses with bit 8 set return a two-cycle ERROR.
  task automatic test_random();
    logic [31:0] smem [16];
    logic [31:0] mmem [16];
    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q [$];
    logic        s_busy, s_write, s_err_done;
    logic [31:0] s_addr, e_rd;
    logic        e_er;
    int          s_wait;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'h0; mmem[i] = 32'h0;
    end
    s_busy = 1'b0; s_write = 1'b0; s_err_done = 1'b0; s_addr = 32'h0; s_wait = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          e_rd = exp_rdata_q.pop_front();
          e_er = exp_err_q.pop_front();
          if (rsp_rdata !== e_rd || rsp_error !== e_er) begin
            errors++; $display("FAIL rand_rsp: cycle %0d rdata=%h error=%b, want %h/%b", cyc, rsp_rdata, rsp_error, e_rd, e_er);
          end
        end
      end
      checks++;
      if (HTRANS !== 2'b00 && HTRANS !== 2'b10) begin
        errors++; $display("FAIL rand_htrans: HTRANS=%b, want 00 or 10", HTRANS);
      end
      HRDATA = $urandom();
      if (s_busy && s_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0;
      end else if (s_busy && s_addr[8]) begin
        HREADY = s_err_done; HRESP = 1'b1; HRDATA = 32'h0;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
        if (s_busy && !s_write) HRDATA = smem[s_addr[5:2]];
      end
      if (cyc < 600 && $urandom_range(0, 3) != 0) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_size  = 3'($urandom_range(0, 2));
        cmd_addr  = (($urandom_range(0, 7) == 0) ? 32'h100 : 32'h0) | (32'($urandom_range(0, 15)) << 2);
        cmd_wdata = $urandom();
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (cmd_valid && cmd_ready) begin
        if (cmd_addr[8]) begin
          exp_rdata_q.push_back(32'h0); exp_err_q.push_back(1'b1);
        end else if (cmd_write) begin
          mmem[cmd_addr[5:2]] = cmd_wdata;
          exp_rdata_q.push_back(32'h0); exp_err_q.push_back(1'b0);
        end else begin
          exp_rdata_q.push_back(mmem[cmd_addr[5:2]]); exp_err_q.push_back(1'b0);
        end
      end
      if (s_busy) begin
        if (s_wait > 0) s_wait--;
        else if (s_addr[8] && !s_err_done) s_err_done = 1'b1;
        else begin
          if (s_write && !s_addr[8]) smem[s_addr[5:2]] = HWDATA;
          s_busy = 1'b0;
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        s_busy = 1'b1; s_addr = HADDR; s_write = HWRITE;
        s_wait = $urandom_range(0, 2); s_err_done = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (exp_err_q.size() != 0) begin
      errors++; $display("FAIL rand_lost: %0d responses never arrived, want 0", exp_err_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error_replay();
    test_reset_abort();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
